seq_monitor: RTL



---
 rtl/seq_pkg.sv | 35 +++
 rtl/seq_next_lut.sv | 15 +
 rtl/seq_monitor.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants, state type and helper functions for the 0,1,3,7,9,11,13,14 sequence
package seq_pkg;

  localparam int SEQ_W   = 4;
  localparam int SEQ_LEN = 8;

  typedef logic [SEQ_W-1:0] code_t;

  // Entry i sits at bits [i*SEQ_W +: SEQ_W]; entry 0 is the first code of the cycle.
  localparam logic [SEQ_LEN*SEQ_W-1:0] SEQ_TBL =
    {4'd14, 4'd13, 4'd11, 4'd9, 4'd7, 4'd3, 4'd1, 4'd0};

  localparam code_t SEQ_FIRST = 4'd0;
  localparam code_t SEQ_LAST  = 4'd14;

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  function automatic logic seq_member(input code_t x);
    logic m;
    m = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (SEQ_TBL[i*SEQ_W +: SEQ_W] == x) m = 1'b1;
    return m;
  endfunction

  // Non-member codes have no successor; they map to 0.
  function automatic code_t seq_next(input code_t x);
    code_t n;
    n = '0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (SEQ_TBL[i*SEQ_W +: SEQ_W] == x) n = SEQ_TBL[((i + 1) % SEQ_LEN)*SEQ_W +: SEQ_W];
    return n;
  endfunction

endpackage

// File: rtl/seq_next_lut.sv
// rtl/seq_next_lut.sv - combinational successor and membership lookup for one sequence code
import seq_pkg::*;

module seq_next_lut (
  input  logic [SEQ_W-1:0] code,
  output logic [SEQ_W-1:0] next_code,
  output logic             member
);

  always_comb begin
    next_code = seq_next(code);
    member    = seq_member(code);
  end

endmodule

// File: rtl/seq_monitor.sv
// rtl/seq_monitor.sv - locks onto the counter sequence, flags illegal steps, keeps error/wrap stats
// Optional: define SEQ_MON_HOLD_OK_EN to accept q_in==prev as a legal hold while tracking.
import seq_pkg::*;

module seq_monitor #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SEQ_W-1:0]  q_in,
  input  logic              clr,
  output logic              locked,
  output logic [SEQ_W-1:0]  exp_q,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  state_t     state, state_d;
  code_t      prev;
  logic [2:0] run, run_d;
  code_t      q_next;
  logic       q_member;
  logic       match, hold, err_hit, wrap_hit;

  seq_next_lut u_lut (
    .code      (q_in),
    .next_code (q_next),
    .member    (q_member)
  );

  // Outside IDLE exp_q already holds next(prev), so it doubles as the match reference.
  assign match = (q_in == exp_q);

`ifdef SEQ_MON_HOLD_OK_EN
  assign hold = (q_in == prev);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    run_d    = run;
    err_hit  = 1'b0;
    wrap_hit = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (q_member) begin
            state_d = SEARCH;
            run_d   = '0;
          end
        end
        SEARCH: begin
          if (!hold) begin
            if (match) begin
              run_d = run + 3'd1;
              if (run_d == 3'(LOCK_CNT)) state_d = LOCKED;
            end else begin
              run_d   = '0;
              state_d = q_member ? SEARCH : IDLE;
            end
          end
        end
        LOCKED: begin
          if (!hold) begin
            if (match) begin
              wrap_hit = (prev == SEQ_LAST) && (q_in == SEQ_FIRST);
            end else begin
              err_hit = 1'b1;
              run_d   = '0;
              state_d = q_member ? SEARCH : IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      exp_q      <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
    end else begin
      err_pulse  <= err_hit;
      wrap_pulse <= wrap_hit;
      if (en) begin
        state  <= state_d;
        run    <= run_d;
        prev   <= q_in;
        locked <= (state_d == LOCKED);
        exp_q  <= (state_d == IDLE) ? '0 : q_next;
      end
      if (clr) begin
        err_cnt  <= '0;
        wrap_cnt <= '0;
      end else begin
        if (err_hit && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
        if (wrap_hit) wrap_cnt <= wrap_cnt + 1'b1;
      end
    end
  end

endmodule
